gemm_stream_ctrl: RTL and testbench

- Parametrised DMA-stream sequencer for the GEMM core; successor to the fixed 16/8/4-bank batch controller.
- Routes inbound AXI-Stream-style beats either to parameter banks (matw=1) or to the source buffer (run=1).
- Backpressures the source while the core computes, then drains result frames to the destination stream with dst_ready backpressure, a last flag and a batch-complete pulse.

---
 rtl/gemm_stream_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_gemm_stream_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gemm_stream_ctrl
// Brief    : GEMM DMA-stream sequencer. It handles parameter-bank loads and
//            source-block capture, then drains result frames with a last flag
//            and a batch-complete pulse. Define GEMM_STREAM_ERR_EN to add a
//            sticky err output.
// Revision : 1.0
// ============================================================================
module gemm_stream_ctrl #(
  parameter int  SRC_DEPTH = 16,
  parameter int  DST_DEPTH = 8,
  parameter int  PRM_BANKS = 4,
  parameter int  PRM_DEPTH = 8,
  parameter int  BW        = 8,
  localparam int SAW       = $clog2(SRC_DEPTH),
  localparam int DAW       = $clog2(DST_DEPTH),
  localparam int PAW       = $clog2(PRM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 matw,
  input  logic                 run,
  input  logic [BW-1:0]        nbatch,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 s_init,
  input  logic                 s_fin,
  output logic                 src_v,
  output logic [SAW-1:0]       src_a,
  output logic [PRM_BANKS-1:0] prm_v,
  output logic [PAW-1:0]       prm_a,
  output logic                 dst_v,
  output logic [DAW-1:0]       dst_a,
  output logic                 dst_valid,
  input  logic                 dst_ready,
  output logic                 dst_last,
  output logic                 batch_done
`ifdef GEMM_STREAM_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int             PSW         = (PRM_BANKS > 1) ? $clog2(PRM_BANKS) : 1;
  localparam logic [SAW-1:0] c_sa_last   = SAW'(SRC_DEPTH - 1);
  localparam logic [DAW-1:0] c_da_last   = DAW'(DST_DEPTH - 1);
  localparam logic [PAW-1:0] c_pa_last   = PAW'(PRM_DEPTH - 1);
  localparam logic [PSW-1:0] c_psel_last = PSW'(PRM_BANKS - 1);

  typedef enum logic [0:0] {S_LOAD = 1'b0, S_WAIT = 1'b1} src_state_t;

  src_state_t     state_q, state_d;
  logic [SAW-1:0] sa_q, sa_d;
  logic [DAW-1:0] da_q, da_d;
  logic [PAW-1:0] pa_q, pa_d;
  logic [PSW-1:0] psel_q, psel_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           active_q, active_d;
  logic           dst_valid_q, dst_valid_d;
  logic           dst_last_q, dst_last_d;
  logic           src_en, last_rd, arm, accept_last;
  logic [BW-1:0]  nb_last;
`ifdef GEMM_STREAM_ERR_EN
  logic           err_q, err_d;
`endif

  always_comb begin
    src_en      = run & ~matw;
    src_ready   = matw | (state_q == S_LOAD);
    src_v       = src_en & (state_q == S_LOAD) & src_valid;
    src_a       = sa_q;
    s_init      = src_v & (sa_q == c_sa_last);
    prm_v       = '0;
    if (matw && src_valid) prm_v[psel_q] = 1'b1;
    prm_a       = pa_q;
    dst_v       = active_q & dst_ready;
    dst_a       = da_q;
    dst_valid   = dst_valid_q;
    dst_last    = dst_last_q;
    last_rd     = dst_v & (da_q == c_da_last);
    // A finish pulse on the final read of a frame chains the next frame.
    arm         = run & s_fin & (~active_q | last_rd);
    accept_last = dst_valid_q & dst_ready & dst_last_q;
    nb_last     = (nbatch == '0) ? '0 : nbatch - 1'b1;
    batch_done  = accept_last & (bcnt_q == nb_last);

    pa_d   = pa_q;
    psel_d = psel_q;
    if (!matw) begin
      pa_d   = '0;
      psel_d = '0;
    end else if (src_valid) begin
      if (pa_q == c_pa_last) begin
        pa_d   = '0;
        psel_d = (psel_q == c_psel_last) ? '0 : psel_q + 1'b1;
      end else begin
        pa_d = pa_q + 1'b1;
      end
    end

    state_d = state_q;
    sa_d    = sa_q;
    if (!src_en) begin
      state_d = S_LOAD;
      sa_d    = '0;
    end else begin
      case (state_q)
        S_LOAD: if (src_valid) begin
          if (sa_q == c_sa_last) begin
            sa_d    = '0;
            state_d = S_WAIT;
          end else begin
            sa_d = sa_q + 1'b1;
          end
        end
        S_WAIT:  if (s_fin) state_d = S_LOAD;
        default: state_d = S_LOAD;
      endcase
    end

    active_d = active_q;
    da_d     = da_q;
    if (dst_v) begin
      if (da_q == c_da_last) begin
        active_d = 1'b0;
        da_d     = '0;
      end else begin
        da_d = da_q + 1'b1;
      end
    end
    if (arm) begin
      active_d = 1'b1;
      da_d     = '0;
    end

    // Output beat stage mirrors the buffer read one cycle later; it stalls with the sink.
    dst_valid_d = dst_valid_q;
    dst_last_d  = dst_last_q;
    if (dst_ready) begin
      dst_valid_d = dst_v;
      dst_last_d  = last_rd;
    end

    bcnt_d = bcnt_q;
    if (accept_last) bcnt_d = (bcnt_q == nb_last) ? '0 : bcnt_q + 1'b1;

    if (!run) begin
      active_d    = 1'b0;
      da_d        = '0;
      dst_valid_d = 1'b0;
      dst_last_d  = 1'b0;
      bcnt_d      = '0;
    end
`ifdef GEMM_STREAM_ERR_EN
    err_d = err_q
          | (s_fin & active_q & ~last_rd)
          | (run & s_fin & (state_q == S_LOAD))
          | (src_en & src_valid & (state_q == S_WAIT));
    if (!run) err_d = 1'b0;
`endif
  end

`ifdef GEMM_STREAM_ERR_EN
  assign err = err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      sa_q        <= '0;
      da_q        <= '0;
      pa_q        <= '0;
      psel_q      <= '0;
      bcnt_q      <= '0;
      active_q    <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
`ifdef GEMM_STREAM_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      da_q        <= da_d;
      pa_q        <= pa_d;
      psel_q      <= psel_d;
      bcnt_q      <= bcnt_d;
      active_q    <= active_d;
      dst_valid_q <= dst_valid_d;
      dst_last_q  <= dst_last_d;
`ifdef GEMM_STREAM_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_stream_ctrl
// Brief    : Directed self-checking bench for gemm_stream_ctrl with default
//            parameters. It also covers err when GEMM_STREAM_ERR_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_gemm_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset, matw, run, src_valid, s_fin, dst_ready;
  logic [7:0] nbatch;
  logic       src_ready, s_init, src_v, dst_v, dst_valid, dst_last, batch_done;
  logic [3:0] src_a;
  logic [3:0] prm_v;
  logic [2:0] prm_a;
  logic [2:0] dst_a;
`ifdef GEMM_STREAM_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit pat [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  gemm_stream_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .matw       (matw),
    .run        (run),
    .nbatch     (nbatch),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .s_init     (s_init),
    .s_fin      (s_fin),
    .src_v      (src_v),
    .src_a      (src_a),
    .prm_v      (prm_v),
    .prm_a      (prm_a),
    .dst_v      (dst_v),
    .dst_a      (dst_a),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .dst_last   (dst_last),
`ifdef GEMM_STREAM_ERR_EN
    .err        (err),
`endif
    .batch_done (batch_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse s_fin for one cycle; returns at the following negedge.
  task automatic pulse_fin();
    @(negedge clk);
    s_fin     = 1'b1;
    dst_ready = 1'b0;
    @(negedge clk);
    s_fin     = 1'b0;
  endtask

  task automatic load_block(input bit chk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      src_valid = 1'b1;
      #1;
      if (chk) begin
        check("src_v", src_v, 1);
        check("src_a", src_a, i);
        check("s_init", s_init, (i == 15));
      end
    end
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  // Drains one armed frame; called at a negedge. At most one beat can be
  // outstanding in the output stage, so valid is expected exactly while issued > accepted.
  task automatic drain(input bit bp, input bit bd_on_last);
    int iss;
    int acc;
    bit exp_valid;
    iss = 0;
    acc = 0;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      if (c > 0) @(negedge clk);
      dst_ready = bp ? pat[c % 5] : 1'b1;
      #1;
      exp_valid = (iss > acc);
      check("dst_valid", dst_valid, exp_valid);
      check("batch_done", batch_done, exp_valid && dst_ready && acc == 7 && bd_on_last);
      if (exp_valid && dst_ready) begin
        check("dst_last", dst_last, (acc == 7));
        acc++;
      end
      check("dst_v", dst_v, dst_ready && iss < 8);
      if (dst_ready && iss < 8) begin
        check("dst_a", dst_a, iss);
        iss++;
      end
    end
    check("drain_beats", acc, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; matw = 1'b0; src_valid = 1'b0;
    s_fin = 1'b0; dst_ready = 1'b0; nbatch = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_src_ready", src_ready, 1);
    check("rst_src_v", src_v, 0);
    check("rst_s_init", s_init, 0);
    check("rst_prm_v", prm_v, 0);
    check("rst_prm_a", prm_a, 0);
    check("rst_dst_v", dst_v, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_dst_last", dst_last, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_src_a", src_a, 0);
    reset = 1'b0;

    // Parameter load: 33 back-to-back beats across four banks.
    @(negedge clk);
    matw = 1'b1;
    src_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("prm_v", prm_v, 1 << ((i / 8) % 4));
      check("prm_a", prm_a, i % 8);
      check("prm_src_ready", src_ready, 1);
    end
    @(negedge clk);
    matw = 1'b0;
    src_valid = 1'b0;

    // Source block, wait for core, then backpressured drain.
    @(negedge clk);
    run = 1'b1;
    load_block(1'b1);
    #1;
    check("wait_src_ready", src_ready, 0);
    @(negedge clk);
    #1;
    check("wait_src_ready2", src_ready, 0);
    @(negedge clk);
    s_fin = 1'b1;
    #1;
    check("fin_src_ready", src_ready, 0);
    @(negedge clk);
    s_fin = 1'b0;
    #1;
    check("post_fin_src_ready", src_ready, 1);
    drain(1'b1, 1'b0);

    // Batch of three frames, then nbatch=0 behaves as 1.
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    nbatch = 8'd3;
    for (int f = 0; f < 3; f++) begin
      pulse_fin();
      drain(1'b0, (f == 2));
    end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    nbatch = 8'd0;
    for (int f = 0; f < 2; f++) begin
      pulse_fin();
      drain(1'b0, 1'b1);
    end

    // Abort during dst beat 4.
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    nbatch = 8'd3;
    pulse_fin();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      dst_ready = 1'b1;
      #1;
      check("abort_dst_a", dst_a, k);
    end
    @(negedge clk);
    run = 1'b0;
    #1;
    check("abort_dst_a4", dst_a, 4);
    @(negedge clk);
    src_valid = 1'b1;
    #1;
    check("abort_dst_v", dst_v, 0);
    check("abort_dst_valid", dst_valid, 0);
    check("abort_dst_last", dst_last, 0);
    check("abort_src_v", src_v, 0);
    src_valid = 1'b0;
    run = 1'b1;
    pulse_fin();
    dst_ready = 1'b1;
    #1;
    check("restart_dst_v", dst_v, 1);
    check("restart_dst_a", dst_a, 0);

    // Abort during src beat 7.
    @(negedge clk);
    dst_ready = 1'b0;
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      src_valid = 1'b1;
      if (i == 7) run = 1'b0;
      #1;
      check("abort_src_a", src_a, i);
    end
    @(negedge clk);
    #1;
    check("abort_src_v2", src_v, 0);
    check("abort_src_ready", src_ready, 1);
    @(negedge clk);
    run = 1'b1;
    #1;
    check("restart_src_v", src_v, 1);
    check("restart_src_a", src_a, 0);
    check("restart_s_init", s_init, 0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    src_valid = 1'b0;
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    pulse_fin();
    dst_ready = 1'b1;
    @(negedge clk);
    #1;
    check("mid_dst_valid", dst_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_dst_valid", dst_valid, 0);
    check("async_dst_v", dst_v, 0);
    check("async_dst_a", dst_a, 0);
    check("async_src_ready", src_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    dst_ready = 1'b0;

`ifdef GEMM_STREAM_ERR_EN
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    #1;
    check("err_clear", err, 0);
    load_block(1'b0);
    s_fin = 1'b1;
    @(negedge clk);
    s_fin = 1'b0;
    dst_ready = 1'b1;
    #1;
    check("err_legal_fin", err, 0);
    @(negedge clk);
    s_fin = 1'b1;
    @(negedge clk);
    s_fin = 1'b0;
    #1;
    check("err_set", err, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      src_valid = 1'b1;
    end
    #1;
    check("err_sticky", err, 1);
    @(negedge clk);
    run = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    #1;
    check("err_run_clear", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
